mem_stage_lsu: RTL and testbench

Memory stage placed directly downstream of the address-generate/execute latch. It accepts one instruction per handshake: an ALU result, a load or a store. Loads and stores go through a valid/ready data-memory port with a response timeout, and the stage stalls upstream while a memory operation is outstanding. The result is registered into the MEM-to-WB output for writeback.

---
 rtl/mem_stage_lsu.sv | 157 +++++++++++++++
 tb/tb_mem_stage_lsu.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// Memory stage: ALU pass-through, word loads/stores over a valid/ready port with timeout.
// Optional forwarding/busy-load outputs are enabled by defining MEM_FWD_EN.
module mem_stage_lsu #(
    parameter int DBITS     = 32,
    parameter int REGNOBITS = 5,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic                 in_is_load,
    input  logic                 in_is_store,
    input  logic                 in_wr_reg,
    input  logic [REGNOBITS-1:0] in_rd,
    input  logic [DBITS-1:0]     in_pc,
    input  logic [DBITS-1:0]     in_alu,
    input  logic [DBITS-1:0]     in_addr,
    input  logic [DBITS-1:0]     in_wdata,
    output logic                 in_ready,
    output logic                 dmem_req_valid,
    input  logic                 dmem_req_ready,
    output logic                 dmem_req_we,
    output logic [DBITS-1:0]     dmem_req_addr,
    output logic [DBITS-1:0]     dmem_req_wdata,
    input  logic                 dmem_rsp_valid,
    input  logic [DBITS-1:0]     dmem_rsp_rdata,
    output logic                 out_valid,
    output logic                 out_wr_reg,
    output logic [REGNOBITS-1:0] out_rd,
    output logic [DBITS-1:0]     out_value,
    output logic [DBITS-1:0]     out_pc,
    output logic                 out_err
`ifdef MEM_FWD_EN
    ,
    output logic                 fwd_valid,
    output logic [REGNOBITS-1:0] fwd_rd,
    output logic [DBITS-1:0]     fwd_value,
    output logic [REGNOBITS-1:0] busy_load_rd,
    output logic                 busy_load
`endif
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    // Last counter value at which the operation may still complete.
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    state_t               state_reg, state_next;
    logic [15:0]          cnt_reg;
    logic [REGNOBITS-1:0] rd_reg;
    logic [DBITS-1:0]     pc_reg;

    logic accept, is_mem, misaligned;
    logic req_fire, rsp_fire, expire;
    logic store_done, load_done, abort, finish;

    assign in_ready       = (state_reg == IDLE);
    assign accept         = in_valid & in_ready;
    assign is_mem         = in_is_load | in_is_store;
    assign misaligned     = (in_addr[1:0] != 2'b00);
    assign dmem_req_valid = (state_reg == REQ);
    assign req_fire       = dmem_req_valid & dmem_req_ready;
    assign rsp_fire       = (state_reg == WAIT) & dmem_rsp_valid;
    assign expire         = (state_reg != IDLE) && (cnt_reg >= TIMEOUT_LAST);
    assign store_done     = req_fire & dmem_req_we;
    assign load_done      = rsp_fire;
    // A handshake or response in the expiry cycle takes priority over the abort.
    assign abort          = expire & ~req_fire & ~rsp_fire;
    assign finish         = store_done | load_done | abort;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept && is_mem && !misaligned) state_next = REQ;
            end
            REQ: begin
                if (req_fire)   state_next = dmem_req_we ? IDLE : WAIT;
                else if (abort) state_next = IDLE;
            end
            WAIT: begin
                if (rsp_fire || abort) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg        <= '0;
            rd_reg         <= '0;
            pc_reg         <= '0;
            dmem_req_we    <= 1'b0;
            dmem_req_addr  <= '0;
            dmem_req_wdata <= '0;
            out_valid      <= 1'b0;
            out_wr_reg     <= 1'b0;
            out_rd         <= '0;
            out_value      <= '0;
            out_pc         <= '0;
            out_err        <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (accept) begin
                if (!is_mem) begin
                    out_valid  <= 1'b1;
                    out_err    <= 1'b0;
                    out_wr_reg <= in_wr_reg & (in_rd != '0);
                    out_value  <= in_alu;
                    out_rd     <= in_rd;
                    out_pc     <= in_pc;
                end else if (misaligned) begin
                    out_valid  <= 1'b1;
                    out_err    <= 1'b1;
                    out_wr_reg <= 1'b0;
                    out_value  <= in_addr;
                    out_rd     <= in_rd;
                    out_pc     <= in_pc;
                end else begin
                    // Load wins when both load and store flags are set.
                    cnt_reg        <= '0;
                    rd_reg         <= in_rd;
                    pc_reg         <= in_pc;
                    dmem_req_we    <= ~in_is_load;
                    dmem_req_addr  <= in_addr;
                    dmem_req_wdata <= in_wdata;
                end
            end else if (state_reg != IDLE) begin
                cnt_reg <= cnt_reg + 16'd1;
                if (finish) begin
                    out_valid  <= 1'b1;
                    out_err    <= abort;
                    out_wr_reg <= load_done & (rd_reg != '0);
                    out_value  <= load_done ? dmem_rsp_rdata : dmem_req_addr;
                    out_rd     <= rd_reg;
                    out_pc     <= pc_reg;
                end
            end
        end
    end

`ifdef MEM_FWD_EN
    assign fwd_valid    = out_valid & out_wr_reg;
    assign fwd_rd       = fwd_valid ? out_rd : '0;
    assign fwd_value    = fwd_valid ? out_value : '0;
    assign busy_load    = (state_reg != IDLE) & ~dmem_req_we;
    assign busy_load_rd = busy_load ? rd_reg : '0;
`endif

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed scenarios plus randomized ops
// checked against a transaction-level latency/result model.
module tb_mem_stage_lsu;
    localparam int TO = 8;

    logic        clk;
    logic        reset;
    logic        in_valid, in_is_load, in_is_store, in_wr_reg;
    logic [4:0]  in_rd;
    logic [31:0] in_pc, in_alu, in_addr, in_wdata;
    logic        in_ready;
    logic        dmem_req_valid, dmem_req_ready, dmem_req_we;
    logic [31:0] dmem_req_addr, dmem_req_wdata;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rsp_rdata;
    logic        out_valid, out_wr_reg, out_err;
    logic [4:0]  out_rd;
    logic [31:0] out_value, out_pc;
`ifdef MEM_FWD_EN
    logic        fwd_valid, busy_load;
    logic [4:0]  fwd_rd, busy_load_rd;
    logic [31:0] fwd_value;
`endif

    int errors = 0;
    int checks = 0;
    int txn    = 0;

    mem_stage_lsu #(.DBITS(32), .REGNOBITS(5), .TIMEOUT(TO)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_is_load     (in_is_load),
        .in_is_store    (in_is_store),
        .in_wr_reg      (in_wr_reg),
        .in_rd          (in_rd),
        .in_pc          (in_pc),
        .in_alu         (in_alu),
        .in_addr        (in_addr),
        .in_wdata       (in_wdata),
        .in_ready       (in_ready),
        .dmem_req_valid (dmem_req_valid),
        .dmem_req_ready (dmem_req_ready),
        .dmem_req_we    (dmem_req_we),
        .dmem_req_addr  (dmem_req_addr),
        .dmem_req_wdata (dmem_req_wdata),
        .dmem_rsp_valid (dmem_rsp_valid),
        .dmem_rsp_rdata (dmem_rsp_rdata),
        .out_valid      (out_valid),
        .out_wr_reg     (out_wr_reg),
        .out_rd         (out_rd),
        .out_value      (out_value),
        .out_pc         (out_pc),
        .out_err        (out_err)
`ifdef MEM_FWD_EN
        ,
        .fwd_valid      (fwd_valid),
        .fwd_rd         (fwd_rd),
        .fwd_value      (fwd_value),
        .busy_load_rd   (busy_load_rd),
        .busy_load      (busy_load)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // kind: 0 ALU, 1 load, 2 store, 3 load+store flags. rdy_d: cycles before
    // dmem_req_ready; rsp_d: WAIT cycles before the response (large = never).
    task automatic do_op(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] alu, input logic [31:0] rdata, input logic [4:0] rd,
                         input logic wr, input logic [31:0] pc, input int rdy_d, input int rsp_d);
        bit is_mem, is_ld, mis, hs, chk_val;
        int exp_lat, req_last, c, rcnt, wcnt;
        logic exp_err, exp_wr;
        logic [31:0] exp_val;

        is_mem  = (kind != 0);
        is_ld   = (kind == 1) || (kind == 3);
        mis     = is_mem && (addr[1:0] != 2'b00);
        exp_val = 32'h0;
        chk_val = 1'b0;
        exp_wr  = 1'b0;
        if (!is_mem) begin
            exp_lat = 1; exp_err = 1'b0; exp_wr = wr && (rd != 0);
            exp_val = alu; chk_val = 1'b1; req_last = 0;
        end else if (mis) begin
            exp_lat = 1; exp_err = 1'b1; exp_val = addr; chk_val = 1'b1; req_last = 0;
        end else begin
            req_last = (rdy_d + 1 < TO) ? rdy_d + 1 : TO;
            if (!is_ld && rdy_d + 1 <= TO) begin
                exp_lat = rdy_d + 2; exp_err = 1'b0;
            end else if (is_ld && rdy_d + rsp_d + 2 <= TO) begin
                exp_lat = rdy_d + rsp_d + 3; exp_err = 1'b0;
                exp_wr = (rd != 0); exp_val = rdata; chk_val = 1'b1;
            end else begin
                exp_lat = TO + 1; exp_err = 1'b1;
            end
        end

        chk("idle_ready", in_ready, 1);
        in_valid    = 1'b1;
        in_is_load  = is_ld;
        in_is_store = (kind == 2) || (kind == 3);
        in_wr_reg   = wr;
        in_rd       = rd;
        in_pc       = pc;
        in_alu      = alu;
        in_addr     = addr;
        in_wdata    = wdata;
        @(negedge clk);
        in_valid = 1'b0;
        c = 1; rcnt = 0; wcnt = 0; hs = 1'b0;
        while (out_valid !== 1'b1 && c <= 40) begin
            chk("busy_ready", in_ready, 0);
            chk("req_valid", dmem_req_valid, (c <= req_last));
            in_valid       = 1'($urandom_range(0, 1));
            dmem_req_ready = 1'b0;
            dmem_rsp_valid = 1'b0;
            if (dmem_req_valid === 1'b1) begin
                chk("req_we", dmem_req_we, !is_ld);
                chk("req_addr", dmem_req_addr, addr);
                if (!is_ld) chk("req_wdata", dmem_req_wdata, wdata);
                dmem_rsp_valid = 1'($urandom_range(0, 1));
                dmem_rsp_rdata = $urandom;
                if (rcnt == rdy_d) begin
                    dmem_req_ready = 1'b1;
                    hs = 1'b1;
                end
                rcnt++;
            end else if (hs && is_ld) begin
                if (wcnt == rsp_d) begin
                    dmem_rsp_valid = 1'b1;
                    dmem_rsp_rdata = rdata;
                end
                wcnt++;
            end
            @(negedge clk);
            c++;
        end
        in_valid       = 1'b0;
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        if (c > 40) begin
            chk("completion_bound", 0, 1);
        end else begin
            chk("latency", c, exp_lat);
            chk("out_err", out_err, exp_err);
            chk("out_wr_reg", out_wr_reg, exp_wr);
            chk("out_rd", out_rd, rd);
            chk("out_pc", out_pc, pc);
            chk("req_drop", dmem_req_valid, 0);
            if (chk_val) chk("out_value", out_value, exp_val);
`ifdef MEM_FWD_EN
            chk("fwd_valid", fwd_valid, exp_wr);
`endif
        end
        $display("txn %0d kind=%0d addr=%h rdy_d=%0d rsp_d=%0d lat=%0d err=%0b val=%h",
                 txn, kind, addr, rdy_d, rsp_d, c, out_err, out_value);
        txn++;
        @(negedge clk);
        chk("pulse_end", out_valid, 0);
    endtask

    initial begin
        reset = 1'b0;
        in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0; in_wr_reg = 1'b0;
        in_rd = '0; in_pc = '0; in_alu = '0; in_addr = '0; in_wdata = '0;
        dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rsp_rdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_out_value", out_value, 0);
        chk("rst_req_valid", dmem_req_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        reset = 1'b1;
        @(negedge clk);

        // ALU back-to-back
        in_valid = 1'b1; in_is_load = 1'b0; in_is_store = 1'b0; in_wr_reg = 1'b1; in_rd = 5'd3;
        for (int i = 0; i < 3; i++) begin
            in_alu = 32'(5 + i);
            in_pc  = 32'h1000 + 32'(4 * i);
            @(negedge clk);
            chk("b2b_valid", out_valid, 1);
            chk("b2b_value", out_value, 32'(5 + i));
            chk("b2b_ready", in_ready, 1);
            chk("b2b_wr", out_wr_reg, 1);
            $display("txn %0d b2b alu value=%0d", txn, out_value);
            txn++;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_idle", out_valid, 0);

        do_op(1, 32'h100, 32'h0, 32'h55, 32'hDEADBEEF, 5'd9, 1'b1, 32'h2000, 2, 2);
        do_op(2, 32'h204, 32'h1234, 32'h0, 32'h0, 5'd4, 1'b1, 32'h2004, 0, 0);
        do_op(1, 32'h102, 32'h0, 32'h0, 32'h0, 5'd7, 1'b1, 32'h2008, 0, 0);
        do_op(3, 32'h108, 32'h77, 32'h0, 32'hCAFE0001, 5'd2, 1'b0, 32'h200C, 1, 0);
        do_op(1, 32'h300, 32'h0, 32'h0, 32'h0, 5'd6, 1'b1, 32'h2010, 0, 1000);
        do_op(1, 32'h304, 32'h0, 32'h0, 32'h0, 5'd6, 1'b1, 32'h2014, 1000, 0);

        // late response after an abort must be dropped
        dmem_rsp_valid = 1'b1; dmem_rsp_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        dmem_rsp_valid = 1'b0;
        chk("late_rsp_ignored", out_valid, 0);
        chk("late_rsp_ready", in_ready, 1);
        do_op(0, 32'h0, 32'h0, 32'h00AB_CDEF, 32'h0, 5'd8, 1'b1, 32'h2018, 0, 0);

        for (int n = 0; n < 40; n++) begin
            int kind, rdy_d, rsp_d;
            logic [31:0] a;
            kind = $urandom_range(0, 3);
            a = $urandom;
            if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
            rdy_d = $urandom_range(0, TO);
            if ((kind == 1 || kind == 3) && rdy_d + 1 == TO) rdy_d = 0;
            rsp_d = $urandom_range(0, TO);
            do_op(kind, a, $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), $urandom, rdy_d, rsp_d);
        end

        // async reset while a load sits in WAIT
        in_valid = 1'b1; in_is_load = 1'b1; in_is_store = 1'b0;
        in_addr = 32'h40; in_rd = 5'd5; in_pc = 32'h3000;
        @(negedge clk);
        in_valid = 1'b0; dmem_req_ready = 1'b1;
        @(negedge clk);
        dmem_req_ready = 1'b0;
        chk("wait_busy", in_ready, 0);
        #2 reset = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_value", out_value, 0);
        chk("arst_out_pc", out_pc, 0);
        chk("arst_out_rd", out_rd, 0);
        chk("arst_req_addr", dmem_req_addr, 0);
        chk("arst_in_ready", in_ready, 1);
        $display("txn %0d async reset in WAIT", txn);
        txn++;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_quiet", out_valid, 0);
        do_op(0, 32'h0, 32'h0, 32'h0000_0042, 32'h0, 5'd0, 1'b1, 32'h4000, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
